c2s_bus_bridge: RTL

C2S_BUS_BRIDGE -- requirements
Module: c2s_bus_bridge

---
 rtl/c2s_pkg.sv | 13 +
 rtl/c2s_bus_timer.sv | 29 ++
 rtl/c2s_bus_bridge.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/c2s_pkg.sv
// Shared constants and state encoding for the c2sif-to-bus bridge.
package c2s_pkg;
  localparam logic [7:0] FN_WRITE = 8'd1;
  localparam logic [7:0] FN_READ  = 8'd2;

  localparam logic signed [31:0] RET_OK      = 32'sd0;
  localparam logic signed [31:0] RET_BADFN   = -32'sd1;
  localparam logic signed [31:0] RET_BADLEN  = -32'sd2;
  localparam logic signed [31:0] RET_BUSERR  = -32'sd3;
  localparam logic signed [31:0] RET_TIMEOUT = -32'sd4;

  typedef enum logic [1:0] {IDLE, CHECK, XFER, ACK} state_e;
endpackage

// File: rtl/c2s_bus_timer.sv
// Bus-beat wait counter: counts stalled cycles, flags the one that hits TIMEOUT.
module c2s_bus_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Expires on the stalled edge that completes TIMEOUT waiting cycles.
  assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/c2s_bus_bridge.sv
// Bridges one c2sif req/ack packet into a burst of single-word bus beats.
module c2s_bus_bridge
  import c2s_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  output logic                      ack,
  input  logic [31:0]               id,
  input  logic [31:0]               fn,
  input  logic [31:0]               addr,
  input  logic [DATA_SIZE*32-1:0]   wdata,
  output logic [DATA_SIZE*32-1:0]   rdata,
  output logic signed [31:0]        ret,
  output logic [31:0]               rsp_id,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic                      bus_we,
  output logic [31:0]               bus_addr,
  output logic [31:0]               bus_wdata,
  input  logic [31:0]               bus_rdata,
  input  logic                      bus_err
);
  localparam logic [8:0] DS_MAX = 9'(DATA_SIZE);

  state_e                    state_q, state_d;
  logic                      ack_q, ack_d;
  logic [31:0]               id_q, id_d;
  logic [7:0]                op_q, op_d;
  logic [7:0]                len_q, len_d;
  logic [31:0]               addr_q, addr_d;
  logic [DATA_SIZE*32-1:0]   wdata_q, wdata_d;
  logic [DATA_SIZE*32-1:0]   rdata_q, rdata_d;
  logic signed [31:0]        ret_q, ret_d;
  logic [7:0]                beat_q, beat_d;
  logic                      bus_valid_q, bus_valid_d;
  logic                      bus_we_q, bus_we_d;
  logic [31:0]               bus_addr_q, bus_addr_d;
  logic [31:0]               bus_wdata_q, bus_wdata_d;

  logic       hs, expired;
  logic [7:0] beat_nx;
  logic       unused_fn;

  assign hs        = bus_valid_q & bus_ready;
  assign beat_nx   = beat_q + 8'd1;
  assign unused_fn = ^fn[31:16];

  c2s_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (~bus_valid_q | bus_ready),
    .en      (bus_valid_q & ~bus_ready),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    id_d        = id_q;
    op_d        = op_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ret_d       = ret_q;
    beat_d      = beat_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      IDLE: if (req) begin
        id_d    = id;
        op_d    = fn[7:0];
        len_d   = fn[15:8];
        addr_d  = addr;
        wdata_d = wdata;
        rdata_d = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (op_q != FN_WRITE && op_q != FN_READ) begin
          ret_d = RET_BADFN; ack_d = 1'b1; state_d = ACK;
        end else if (len_q == 8'd0 || {1'b0, len_q} > DS_MAX) begin
          ret_d = RET_BADLEN; ack_d = 1'b1; state_d = ACK;
        end else begin
          beat_d      = 8'd0;
          bus_valid_d = 1'b1;
          bus_we_d    = (op_q == FN_WRITE);
          bus_addr_d  = addr_q;
          bus_wdata_d = wdata_q[31:0];
          state_d     = XFER;
        end
      end
      XFER: begin
        if (hs) begin
          // An errored beat ends the burst without touching rdata.
          if (bus_err) begin
            ret_d = RET_BUSERR; bus_valid_d = 1'b0; ack_d = 1'b1; state_d = ACK;
          end else begin
            if (!bus_we_q) rdata_d[beat_q*32 +: 32] = bus_rdata;
            if (beat_q == len_q - 8'd1) begin
              ret_d = RET_OK; bus_valid_d = 1'b0; ack_d = 1'b1; state_d = ACK;
            end else begin
              beat_d      = beat_nx;
              bus_addr_d  = addr_q + {22'd0, beat_nx, 2'b00};
              bus_wdata_d = wdata_q[beat_nx*32 +: 32];
            end
          end
        end else if (expired) begin
          ret_d = RET_TIMEOUT; bus_valid_d = 1'b0; ack_d = 1'b1; state_d = ACK;
        end
      end
      ACK: if (!req) begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      id_q        <= '0;
      op_q        <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ret_q       <= '0;
      beat_q      <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      id_q        <= id_d;
      op_q        <= op_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ret_q       <= ret_d;
      beat_q      <= beat_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign ret       = ret_q;
  assign rsp_id    = id_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
endmodule
